// File: rtl/pll_ce_pkg.sv
// pll_ce_pkg: shared definitions for the pll_ce_gen clock-enable generator.
//   - configuration field codes carried in daddr[1:0]
//   - lock sequencer state encoding
//   - cfg_legal(): legality rule for a channel's {MUL, DIV, PHASE} triple
package pll_ce_pkg;

  localparam logic [1:0] FLD_MUL   = 2'd0;
  localparam logic [1:0] FLD_DIV   = 2'd1;
  localparam logic [1:0] FLD_PHASE = 2'd2;
  localparam logic [1:0] FLD_RSVD  = 2'd3;

  // cfg_legal() takes fixed-width arguments so that it does not depend on a
  // module parameter. Callers zero-extend, which limits ACC_W to 32 bits.
  localparam int CFG_W = 32;

  typedef enum logic {
    ST_COUNT,
    ST_LOCKED
  } lock_state_t;

  // A channel configuration is usable when 1 <= MUL <= DIV and PHASE < DIV.
  // MUL >= 1 and MUL <= DIV together already imply DIV >= 1.
  function automatic logic cfg_legal(input logic [CFG_W-1:0] mul,
                                     input logic [CFG_W-1:0] div,
                                     input logic [CFG_W-1:0] phase);
    return (mul != '0) && (mul <= div) && (div != '0) && (phase < div);
  endfunction

endpackage

// File: rtl/pll_ce_chan.sv
// pll_ce_chan: one rational-rate clock-enable channel.
// Holds the MUL/DIV/PHASE configuration and the phase accumulator. While
// running, it adds MUL every cycle and emits an enable pulse whenever the
// accumulator wraps past DIV, so the long-run pulse rate is exactly MUL/DIV.
// Ports:
//   refclk, reset  clock and synchronous active-high reset
//   wr_en          write the field selected by 'field' with 'di'
//   field, di      configuration field code and write data
//   load_phase     preset the accumulator with PHASE (lock moment)
//   run            advance the accumulator this cycle
//   mul/div/phase  current configuration, used by the top for validation
//   clk_en         registered single-cycle enable pulse
module pll_ce_chan
  import pll_ce_pkg::*;
#(
  parameter int ACC_W     = 16,
  parameter int DEF_MUL   = 1,
  parameter int DEF_DIV   = 2,
  parameter int DEF_PHASE = 0
) (
  input  logic             refclk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [1:0]       field,
  input  logic [ACC_W-1:0] di,
  input  logic             load_phase,
  input  logic             run,
  output logic [ACC_W-1:0] mul,
  output logic [ACC_W-1:0] div,
  output logic [ACC_W-1:0] phase,
  output logic             clk_en
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  // One extra bit so acc + MUL can never overflow before the compare.
  assign sum = {1'b0, acc} + {1'b0, mul};

  // NOTE: sequential state is assigned with non-blocking (<=) only, so every
  // flop samples the pre-edge values regardless of statement order.
  // NOTE: the configuration registers are individual flops, not a RAM, and
  // must reset to their defaults; a RAM-style array would lose its reset.
  always_ff @(posedge refclk) begin
    if (reset) begin
      mul    <= ACC_W'(DEF_MUL);
      div    <= ACC_W'(DEF_DIV);
      phase  <= ACC_W'(DEF_PHASE);
      acc    <= '0;
      clk_en <= 1'b0;
    end else begin
      if (wr_en) begin
        case (field)
          FLD_MUL:   mul   <= di;
          FLD_DIV:   div   <= di;
          FLD_PHASE: phase <= di;
          default:   ;
        endcase
      end

      if (load_phase) begin
        acc    <= phase;
        clk_en <= 1'b0;
      end else if (run) begin
        if (sum >= {1'b0, div}) begin
          acc    <= ACC_W'(sum - {1'b0, div});
          clk_en <= 1'b1;
        end else begin
          acc    <= ACC_W'(sum);
          clk_en <= 1'b0;
        end
      end else begin
        clk_en <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pll_ce_gen.sv
// pll_ce_gen: NUM_CH independent rational-rate clock enables in the refclk
// domain, with PLL-style lock sequencing and a dynamic configuration port.
// Ports:
//   refclk   sole clock
//   reset    synchronous active-high reset
//   dwe      configuration write strobe (one cycle per write)
//   daddr    {channel, field}; field 0=MUL, 1=DIV, 2=PHASE, 3=reserved
//   di       write data
//   clk_en   per-channel single-cycle enable pulses (registered)
//   extlock  high while the enables are valid (registered)
//   cfg_err  one-cycle pulse after a rejected write (registered)
module pll_ce_gen
  import pll_ce_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int ACC_W       = 16,
  parameter int LOCK_CYCLES = 64,
  parameter int DEF_MUL     = 1,
  parameter int DEF_DIV     = 2,
  parameter int DEF_PHASE   = 0
) (
  input  logic                      refclk,
  input  logic                      reset,
  input  logic                      dwe,
  input  logic [$clog2(NUM_CH)+1:0] daddr,
  input  logic [ACC_W-1:0]          di,
  output logic [NUM_CH-1:0]         clk_en,
  output logic                      extlock,
  output logic                      cfg_err
);

  localparam int AW    = $clog2(NUM_CH) + 2;
  // LOCK_CYCLES-1 is the largest count value and always fits in this width.
  localparam int CNT_W = $clog2(LOCK_CYCLES);

  lock_state_t      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             lock_now;

  logic [AW-1:0]    ch_sel;
  logic [1:0]       field;
  logic             ch_ok;
  logic [ACC_W-1:0] cur_mul, cur_div, cur_phase;
  logic [ACC_W-1:0] new_mul, new_div, new_phase;
  logic             wr_legal, wr_bad;
  logic             run;

  logic [ACC_W-1:0] mul_v   [NUM_CH];
  logic [ACC_W-1:0] div_v   [NUM_CH];
  logic [ACC_W-1:0] phase_v [NUM_CH];

  // Shifting keeps this valid for NUM_CH == 1, where daddr has no channel bits.
  assign ch_sel = daddr >> 2;
  assign field  = daddr[1:0];

  // Validate the candidate triple: the addressed channel's shadow values
  // with the written field replaced. Out-of-range channels read as zeros,
  // which fail cfg_legal, but ch_ok is checked explicitly as well.
  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    cur_mul   = '0;
    cur_div   = '0;
    cur_phase = '0;
    ch_ok     = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == AW'(i)) begin
        ch_ok     = 1'b1;
        cur_mul   = mul_v[i];
        cur_div   = div_v[i];
        cur_phase = phase_v[i];
      end
    end

    new_mul   = cur_mul;
    new_div   = cur_div;
    new_phase = cur_phase;
    case (field)
      FLD_MUL:   new_mul   = di;
      FLD_DIV:   new_div   = di;
      FLD_PHASE: new_phase = di;
      default:   ;
    endcase

    wr_legal = dwe && ch_ok && (field != FLD_RSVD) &&
               cfg_legal(CFG_W'(new_mul), CFG_W'(new_div), CFG_W'(new_phase));
    wr_bad   = dwe && !wr_legal;
  end

  // Lock sequencer. Any legal write restarts the count from zero, and a
  // legal write while locked also drops lock.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    lock_now   = 1'b0;
    case (state)
      ST_COUNT: begin
        if (wr_legal) begin
          cnt_next = '0;
        end else if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
          state_next = ST_LOCKED;
          cnt_next   = '0;
          lock_now   = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ST_LOCKED: begin
        if (wr_legal) begin
          state_next = ST_COUNT;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = ST_COUNT;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge refclk) begin
    if (reset) begin
      state   <= ST_COUNT;
      cnt     <= '0;
      extlock <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      extlock <= (state_next == ST_LOCKED);
      cfg_err <= wr_bad;
    end
  end

  // Channels stop (enables forced low) on the edge that accepts a write
  // while locked, so clk_en and extlock fall together.
  assign run = (state == ST_LOCKED) && !wr_legal;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    pll_ce_chan #(
      .ACC_W     (ACC_W),
      .DEF_MUL   (DEF_MUL),
      .DEF_DIV   (DEF_DIV),
      .DEF_PHASE (DEF_PHASE)
    ) u_chan (
      .refclk     (refclk),
      .reset      (reset),
      .wr_en      (wr_legal && (ch_sel == AW'(g))),
      .field      (field),
      .di         (di),
      .load_phase (lock_now),
      .run        (run),
      .mul        (mul_v[g]),
      .div        (div_v[g]),
      .phase      (phase_v[g]),
      .clk_en     (clk_en[g])
    );
  end

endmodule
